tick_timer: RTL and testbench

Programmable down-counting timer that consumes the periodic one-cycle strobe from the upstream tick generator (one pulse every 5 clk). It counts a loaded number of ticks and raises a one-cycle expire pulse at the end of the count. It supports one-shot and periodic (auto-reload) modes, stop, retrigger and a saturating expiration counter. It sits directly downstream of the tick generator and feeds event/status logic.

---
 rtl/tick_timer.sv | 137 +++++++++++++
 tb/tb_tick_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Purpose: programmable down-counting timer driven by an upstream tick strobe; one-shot or periodic.
// Latency: expire is registered and rises on the edge that samples the load_val-th accepted tick.
// Backpressure: none; start/stop/tick are one-cycle requests that are always accepted.
module tick_timer #(
  parameter int W  = 10,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [W-1:0]  load_val,
  output logic          busy,
  output logic          expire,
  output logic [W-1:0]  remain,
  output logic [EW-1:0] expire_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0]  REM_ONE = W'(1);
  localparam logic [EW-1:0] CNT_ONE = EW'(1);
  localparam logic [EW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  remain_q, remain_d;
  logic [W-1:0]  period_q, period_d;
  logic          mode_q, mode_d;
  logic          expire_q, expire_d;
  logic [EW-1:0] cnt_q, cnt_d;

  logic [EW-1:0] cnt_inc;
  logic          load_zero;

  // Saturating increment so the expiration count sticks at its maximum instead of wrapping.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign load_zero = (load_val == '0);

  // Next-state logic: priority stop > start > tick; a zero-length start expires immediately and idles.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        // tick and stop carry no meaning while idle.
        if (start) begin
          if (load_zero) begin
            expire_d = 1'b1;
            cnt_d    = CNT_ONE;
            remain_d = '0;
          end else begin
            period_d = load_val;
            mode_d   = mode;
            remain_d = load_val;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // Abort wins even over a coincident final tick: no expire, count preserved.
          remain_d = '0;
          state_d  = IDLE;
        end else if (start) begin
          // Retrigger: the coincident tick, if any, belongs to the old period and is dropped.
          if (load_zero) begin
            expire_d = 1'b1;
            cnt_d    = CNT_ONE;
            remain_d = '0;
            state_d  = IDLE;
          end else begin
            period_d = load_val;
            mode_d   = mode;
            remain_d = load_val;
            cnt_d    = '0;
          end
        end else if (tick) begin
          if (remain_q > REM_ONE) begin
            remain_d = remain_q - REM_ONE;
          end else begin
            // Last tick of the period: pulse, then reload or fall back to idle.
            expire_d = 1'b1;
            cnt_d    = cnt_inc;
            if (mode_q) begin
              remain_d = period_q;
            end else begin
              remain_d = '0;
              state_d  = IDLE;
            end
          end
        end
      end

      default: begin
        state_d  = IDLE;
        remain_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign expire     = expire_q;
  assign remain     = remain_q;
  assign expire_cnt = cnt_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios followed by random traffic.
// Two instances share stimulus; the second has a 2-bit expiration counter to exercise saturation.
// Expected values come from a tick-count model: remain = period - (ticks mod period).
module tb_tick_timer;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, tick, start, stop, mode;
  logic [W-1:0] load_val;

  logic         busy, expire;
  logic [W-1:0] remain;
  logic [7:0]   expire_cnt;
  logic         busy2, expire2;
  logic [W-1:0] remain2;
  logic [1:0]   expire_cnt2;

  tick_timer #(.W(W), .EW(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .mode(mode), .load_val(load_val),
    .busy(busy), .expire(expire), .remain(remain), .expire_cnt(expire_cnt)
  );

  tick_timer #(.W(W), .EW(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .mode(mode), .load_val(load_val),
    .busy(busy2), .expire(expire2), .remain(remain2), .expire_cnt(expire_cnt2)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: ticks accepted since the last load, and total expirations.
  bit m_run    = 0;
  bit m_mode   = 0;
  bit m_exp    = 0;
  int m_period = 0;
  int m_n      = 0;
  int m_count  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_exp = 0;
    if (rst) begin
      m_run = 0; m_period = 0; m_mode = 0; m_n = 0; m_count = 0;
    end else if (m_run && stop) begin
      m_run = 0;
    end else if (start) begin
      if (load_val == 0) begin
        m_run = 0; m_exp = 1; m_count = 1;
      end else begin
        m_run = 1; m_period = int'(load_val); m_mode = mode; m_n = 0; m_count = 0;
      end
    end else if (m_run && tick) begin
      m_n++;
      if (m_n % m_period == 0) begin
        m_exp = 1;
        m_count++;
        if (!m_mode) m_run = 0;
      end
    end
  endtask

  task automatic check_all();
    int exp_rem;
    int sat8;
    int sat2;
    exp_rem = m_run ? (m_period - (m_n % m_period)) : 0;
    sat8 = (m_count > 255) ? 255 : m_count;
    sat2 = (m_count > 3) ? 3 : m_count;
    chk("busy", 32'(busy), 32'(m_run));
    chk("expire", 32'(expire), 32'(m_exp));
    chk("remain", 32'(remain), 32'(exp_rem));
    chk("expire_cnt", 32'(expire_cnt), 32'(sat8));
    chk("busy_ew2", 32'(busy2), 32'(m_run));
    chk("expire_ew2", 32'(expire2), 32'(m_exp));
    chk("remain_ew2", 32'(remain2), 32'(exp_rem));
    chk("expire_cnt_ew2", 32'(expire_cnt2), 32'(sat2));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic step(input bit r, input bit st, input bit sp, input bit t, input bit md, input int lv);
    rst = r; start = st; stop = sp; tick = t; mode = md; load_val = W'(lv);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Upstream-style ticks (one every 5 clk) with mode/load_val wiggling but no start.
  task automatic run_ticks(input int cycles);
    for (int k = 0; k < cycles; k++)
      step(0, 0, 0, (k % 5) == 4, 1'($urandom), int'($urandom_range(0, 1023)));
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; stop = 0; mode = 0; load_val = '0;

    // Reset state, including reset overriding every other request.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 5);

    // Reset in the middle of a periodic run, then a tick that must do nothing.
    step(0, 1, 0, 0, 1, 7);
    run_ticks(15);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // One-shot of 3 ticks.
    step(0, 1, 0, 0, 0, 3);
    run_ticks(20);

    // Periodic of 2 ticks over 10 ticks, then stop.
    step(0, 1, 0, 0, 1, 2);
    run_ticks(50);
    step(0, 0, 1, 0, 0, 0);

    // Stop coinciding with the final tick, then stop while idle.
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 9);

    // Retrigger with a coincident tick.
    step(0, 1, 0, 0, 0, 4);
    run_ticks(10);
    step(0, 1, 0, 1, 0, 6);
    run_ticks(35);

    // Zero-length load from idle and from run.
    step(0, 1, 0, 0, 0, 0);
    run_ticks(5);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 5);
    run_ticks(7);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Tick held high with period 1: counter saturation on both widths.
    step(0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 300; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      bit r_rst, r_start, r_stop, r_tick, r_mode;
      int r_lv;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_start = ($urandom_range(0, 19) == 0);
      r_stop  = ($urandom_range(0, 39) == 0);
      r_tick  = ($urandom_range(0, 2) == 0);
      r_mode  = 1'($urandom);
      r_lv    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(0, 6));
      step(r_rst, r_start, r_stop, r_tick, r_mode, r_lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
